// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, word-addressed instruction memory and the
// IF/ID pipeline register, with jump/branch redirect (flush) and hazard stall.
module if_stage #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          Stall,
    input  logic                          Branch,
    input  logic                          Zero,
    input  logic [31:0]                   BrPC4,
    input  logic [31:0]                   BrOff,
    input  logic                          Jump,
    input  logic [25:0]                   JTarget,
    input  logic                          ImWe,
    input  logic [$clog2(IMEM_DEPTH)-1:0] ImAddr,
    input  logic [31:0]                   ImData,
    output logic [31:0]                   PC,
    output logic [31:0]                   Ins,
    output logic [31:0]                   PC4,
    output logic                          Valid
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [31:0] imem_q [IMEM_DEPTH];

    logic [31:0] pc_q, pc_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic [AW-1:0] fetch_idx;
    logic [31:0]   fetch_word;
    logic [31:0]   pc_plus4;
    logic [31:0]   br_target;
    logic [31:0]   j_target;
    logic          br_taken;

    // Memory is never reset, so boot loads survive a pipeline reset.
    always_ff @(posedge CLK) begin
        if (ImWe) begin
            imem_q[ImAddr] <= ImData;
        end
    end

    // Upper PC bits are dropped, so fetch wraps around the memory.
    assign fetch_idx  = pc_q[AW+1:2];
    assign fetch_word = imem_q[fetch_idx];
    assign pc_plus4   = pc_q + 32'd4;
    assign br_target  = BrPC4 + (BrOff << 2);
    assign j_target   = {pc4_q[31:28], JTarget, 2'b00};
    assign br_taken   = Branch && Zero;

    always_comb begin
        pc_d    = pc_q;
        ins_d   = ins_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (Jump || br_taken) begin
            // Redirect flushes IF/ID even when a stall is requested.
            pc_d    = Jump ? j_target : br_target;
            ins_d   = 32'd0;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end else if (!Stall) begin
            pc_d    = pc_plus4;
            ins_d   = fetch_word;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            pc_q    <= RESET_PC;
            ins_q   <= 32'd0;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign PC    = pc_q;
    assign Ins   = ins_q;
    assign PC4   = pc4_q;
    assign Valid = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Fetch-stage bench: directed boot/stall/redirect scenarios followed by random
// traffic, all compared against an arithmetic model of the fetch rules.
module tb_if_stage;

    localparam int DEPTH = 64;

    logic        CLK = 1'b0;
    logic        RST, Stall, Branch, Zero, Jump, ImWe;
    logic [31:0] BrPC4, BrOff, ImData;
    logic [25:0] JTarget;
    logic [5:0]  ImAddr;
    logic [31:0] PC, Ins, PC4;
    logic        Valid;

    if_stage #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .Stall(Stall), .Branch(Branch), .Zero(Zero),
        .BrPC4(BrPC4), .BrOff(BrOff), .Jump(Jump), .JTarget(JTarget),
        .ImWe(ImWe), .ImAddr(ImAddr), .ImData(ImData),
        .PC(PC), .Ins(Ins), .PC4(PC4), .Valid(Valid)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] boot   [DEPTH];
    logic [31:0] m_mem  [DEPTH];
    logic [31:0] m_pc   = 32'd0;
    logic [31:0] m_ins  = 32'd0;
    logic [31:0] m_pc4  = 32'd0;
    logic        m_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: one edge of the fetch stage, evaluated on the pre-edge inputs.
    task automatic model_step();
        logic [31:0] fw;
        fw = m_mem[(m_pc >> 2) % DEPTH];
        if (!RST) begin
            m_pc = 32'd0; m_ins = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
        end else if (Jump) begin
            m_pc = (m_pc4 & 32'hF000_0000) | (32'(JTarget) * 4);
            m_ins = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
        end else if (Branch && Zero) begin
            m_pc = BrPC4 + BrOff * 4;
            m_ins = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
        end else if (!Stall) begin
            m_ins = fw; m_pc4 = m_pc + 4; m_valid = 1'b1; m_pc = m_pc + 4;
        end
        if (ImWe) m_mem[ImAddr] = ImData;
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        chk("model_pc",    PC,           m_pc);
        chk("model_ins",   Ins,          m_ins);
        chk("model_pc4",   PC4,          m_pc4);
        chk("model_valid", 32'(Valid),   32'(m_valid));
    endtask

    task automatic idle();
        Stall = 0; Branch = 0; Zero = 0; Jump = 0; ImWe = 0;
        BrPC4 = 0; BrOff = 0; JTarget = 0; ImAddr = 0; ImData = 0;
    endtask

    initial begin
        idle();
        RST = 0;
        // Boot load under reset: fixed program at 0..2, random filler elsewhere.
        for (int i = 0; i < DEPTH; i++) begin
            case (i)
                0:       boot[i] = 32'h0022_1820;
                1:       boot[i] = 32'h2022_0064;
                2:       boot[i] = 32'h8C22_0004;
                default: boot[i] = $urandom;
            endcase
            ImWe = 1; ImAddr = 6'(i); ImData = boot[i];
            tick();
        end
        idle();
        tick(); tick();
        chk("rst_pc", PC, 32'd0); chk("rst_ins", Ins, 32'd0);
        chk("rst_pc4", PC4, 32'd0); chk("rst_valid", 32'(Valid), 32'd0);

        RST = 1;
        tick();
        chk("first_ins", Ins, 32'h0022_1820); chk("first_pc4", PC4, 32'd4);
        chk("first_pc", PC, 32'd4); chk("first_valid", 32'(Valid), 32'd1);
        tick();
        chk("seq1_ins", Ins, 32'h2022_0064); chk("seq1_pc", PC, 32'd8);
        tick();
        chk("seq2_ins", Ins, 32'h8C22_0004); chk("seq2_pc", PC, 32'd12);

        // Back to PC=8 for the stall scenario.
        RST = 0; tick(); RST = 1; tick(); tick();
        Stall = 1; tick(); tick();
        chk("stall_pc", PC, 32'd8); chk("stall_ins", Ins, 32'h2022_0064);
        Stall = 0; tick();
        chk("unstall_ins", Ins, 32'h8C22_0004); chk("unstall_pc", PC, 32'd12);

        Branch = 1; Zero = 1; BrPC4 = 32'd8; BrOff = 32'h10;
        tick();
        chk("br_pc", PC, 32'h48); chk("br_valid", 32'(Valid), 32'd0); chk("br_ins", Ins, 32'd0);
        idle(); tick();
        chk("br_fetch", Ins, boot[18]); chk("br_fetch_pc", PC, 32'h4C);
        Branch = 1; Zero = 0; BrPC4 = 32'd8; BrOff = 32'h10;
        tick();
        chk("nt_ins", Ins, boot[19]); chk("nt_pc", PC, 32'h50); chk("nt_valid", 32'(Valid), 32'd1);
        idle();

        // Jump beats a simultaneous taken branch and stall.
        RST = 0; tick(); RST = 1; tick(); tick();
        chk("pre_jump_pc4", PC4, 32'd8);
        Jump = 1; JTarget = 26'h400; Branch = 1; Zero = 1; Stall = 1; BrPC4 = 32'd8; BrOff = 32'h10;
        tick();
        chk("jump_pc", PC, 32'h1000); chk("jump_valid", 32'(Valid), 32'd0);
        idle(); tick();
        chk("wrap_ins", Ins, 32'h0022_1820); chk("wrap_pc", PC, 32'h1004);

        // Write to the index being fetched on the same edge.
        ImWe = 1; ImAddr = 6'd1; ImData = 32'hDEAD_BEEF;
        tick();
        chk("rdw_old", Ins, 32'h2022_0064);
        idle();
        RST = 0; tick();
        chk("mid_rst_pc", PC, 32'd0);
        RST = 1; tick(); tick();
        chk("mem_kept", Ins, 32'hDEAD_BEEF);

        for (int c = 0; c < 600; c++) begin
            RST     = ($urandom_range(0, 31) != 0);
            Jump    = ($urandom_range(0, 15) == 0);
            Branch  = ($urandom_range(0, 7) == 0);
            Zero    = 1'($urandom);
            Stall   = ($urandom_range(0, 3) == 0);
            ImWe    = ($urandom_range(0, 3) == 0);
            ImAddr  = 6'($urandom);
            ImData  = $urandom;
            BrPC4   = $urandom;
            BrOff   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed($urandom_range(0, 63)) - 32);
            JTarget = 26'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
Parameters:
REQ-001 The module SHALL declare parameter IMEM_DEPTH, default 64, giving the instruction-memory depth in 32-bit words (power of two).
REQ-002 The module SHALL declare parameter RESET_PC, default 32'h00000000, giving the PC value loaded on reset.

Ports:
REQ-003 CLK  in  1  system clock; all state SHALL update on the rising edge.
REQ-004 RST  in  1  reset, synchronous and active-low (0 = reset, sampled on the CLK rising edge).
REQ-005 Stall  in  1  hazard stall; holds PC and the IF/ID register.
REQ-006 Branch  in  1  branch instruction resolved this cycle.
REQ-007 Zero  in  1  ALU zero flag; with Branch it marks the branch taken.
REQ-008 BrPC4  in  32  PC+4 of the branch instruction.
REQ-009 BrOff  in  32  sign-extended branch immediate (Ed32 from the decode stage).
REQ-010 Jump  in  1  jump decoded in ID this cycle.
REQ-011 JTarget  in  26  jump field Ins[25:0] of the instruction in ID.
REQ-012 ImWe  in  1  instruction-memory write enable (bench/boot load).
REQ-013 ImAddr  in  log2(IMEM_DEPTH)  instruction-memory word address for loads.
REQ-014 ImData  in  32  instruction-memory write data.
REQ-015 PC  out  32  current fetch address register.
REQ-016 Ins  out  32  IF/ID instruction register, feeding the decode stage Ins input.
REQ-017 PC4  out  32  IF/ID register holding the fetched instruction's PC+4.
REQ-018 Valid  out  1  IF/ID holds a real instruction; 0 = bubble.

Function
REQ-019 Memory: internal IMEM_DEPTH x 32 array; combinational read at index PC[log2(IMEM_DEPTH)+1:2]; upper PC bits ignored, so fetch index wraps.
REQ-020 Memory write: when ImWe=1, ImData is written to ImAddr at the rising edge, independent of RST and Stall.
REQ-021 Same-edge write and read at one index: IF/ID captures the old word; the new word is visible from the next cycle.
REQ-022 Taken branch: Branch=1 and Zero=1; Branch=1 with Zero=0 SHALL have no effect.
REQ-023 Branch target = BrPC4 + (BrOff << 2), 32-bit, wrapping modulo 2^32.
REQ-024 Jump target = {PC4[31:28], JTarget, 2'b00}, with PC4 taken from the current IF/ID register output.
REQ-025 Per-edge priority: reset > Jump > taken branch > Stall > sequential.
REQ-026 Jump or taken branch: PC <= target; Ins <= 0; PC4 <= 0; Valid <= 0 (flush), regardless of Stall.
REQ-027 Stall with no redirect: PC, Ins, PC4 and Valid hold their values.
REQ-028 Sequential: Ins <= imem[index]; PC4 <= PC+4; Valid <= 1; PC <= PC+4, wrapping modulo 2^32.
REQ-029 Latency: an instruction at address A appears on Ins one edge after PC = A, given no stall or redirect.

Reset
REQ-030 When RST=0 at an edge: PC <= RESET_PC; Ins <= 0; PC4 <= 0; Valid <= 0; Stall, Branch and Jump are ignored.
REQ-031 Reset SHALL NOT clear instruction-memory contents; a reset asserted mid-stall or mid-redirect fully overrides it.
REQ-032 The first fetch occurs on the first edge with RST=1, from RESET_PC.

Verification
REQ-033 Preload imem[0..2] = 00221820, 20220064, 8C220004; hold RST=0 for 2 edges -> PC=0, Ins=0, PC4=0, Valid=0; first edge with RST=1 -> Ins=00221820, PC4=4, PC=4, Valid=1.
REQ-034 Two further edges -> Ins=20220064 then 8C220004; PC=8 then 12.
REQ-035 With PC=8, set Stall=1 for 2 edges -> PC stays 8, Ins stays 20220064; release -> Ins=8C220004.
REQ-036 Branch=1, Zero=1, BrPC4=8, BrOff=0x10 -> PC=0x48, Valid=0, Ins=0; next edge -> Ins=imem[18]. Repeat with Zero=0 -> sequential fetch.
REQ-037 PC4 output=8, Jump=1, JTarget=0x400, Branch=1, Zero=1, Stall=1 at the same edge -> PC=0x1000 (jump wins); next edge fetches imem[0] (index wrap).
REQ-038 ImWe=1 to the index being fetched at the same edge -> Ins gets the old word; RST=0 mid-stream -> PC=0, memory retained.
